// File: rtl/latch_out_debounce.sv
// ---------------------------------------------------------------------------
// latch_out_debounce
//   Conditions the level coming from a D latch output for the clocked domain.
//   The raw level is passed through a two-flop synchroniser. A new level is
//   accepted only after STABLE_CYCLES consecutive synchronised samples agree.
//   Each accepted change produces a one-cycle rise or fall pulse. Each
//   accepted rising edge also increments a wrapping event counter.
//
// Ports
//   clock        in   1      system clock, rising-edge active
//   reset        in   1      asynchronous, active-high reset
//   d_in         in   1      raw latch level, asynchronous to clock
//   count_clear  in   1      synchronous clear of edge_count
//   level_out    out  1      debounced level
//   rise_pulse   out  1      one-cycle pulse on an accepted 0->1 change
//   fall_pulse   out  1      one-cycle pulse on an accepted 1->0 change
//   edge_count   out  CNT_W  accepted rising edges, modulo 2^CNT_W
// ---------------------------------------------------------------------------
module latch_out_debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             d_in,
    input  logic             count_clear,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_count
);

    localparam int SC_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [SC_W-1:0] LAST_CNT = SC_W'(STABLE_CYCLES - 1);
    localparam logic [SC_W-1:0] ONE_CNT  = SC_W'(1);

    localparam logic [1:0] IDLE_LOW   = 2'd0;
    localparam logic [1:0] CHECK_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH  = 2'd2;
    localparam logic [1:0] CHECK_LOW  = 2'd3;

    logic             sync1_q, sync2_q;
    logic [1:0]       state_q, state_d;
    logic [SC_W-1:0]  stab_cnt_q, stab_cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state logic. The FSM only ever looks at sync2_q, never the raw input.
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        level_d    = level_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;

        case (state_q)
            IDLE_LOW: begin
                if (sync2_q) begin
                    state_d    = CHECK_HIGH;
                    stab_cnt_d = ONE_CNT;
                end
            end
            CHECK_HIGH: begin
                if (!sync2_q) begin
                    state_d    = IDLE_LOW;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == LAST_CNT) begin
                    state_d    = IDLE_HIGH;
                    stab_cnt_d = '0;
                    level_d    = 1'b1;
                    rise_d     = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + ONE_CNT;
                end
            end
            IDLE_HIGH: begin
                if (!sync2_q) begin
                    state_d    = CHECK_LOW;
                    stab_cnt_d = ONE_CNT;
                end
            end
            default: begin
                if (sync2_q) begin
                    state_d    = IDLE_HIGH;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == LAST_CNT) begin
                    state_d    = IDLE_LOW;
                    stab_cnt_d = '0;
                    level_d    = 1'b0;
                    fall_d     = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + ONE_CNT;
                end
            end
        endcase

        // A clear coinciding with an accepted rise still counts that rise.
        count_d = count_q;
        if (rise_d) begin
            count_d = count_clear ? CNT_W'(1) : count_q + CNT_W'(1);
        end else if (count_clear) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            state_q    <= IDLE_LOW;
            stab_cnt_q <= '0;
            level_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            sync1_q    <= d_in;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            count_q    <= count_d;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign edge_count = count_q;

endmodule

// File: tb/tb_latch_out_debounce.sv
// ---------------------------------------------------------------------------
// tb_latch_out_debounce
//   Drives two instances (default counter width and a 2-bit counter) from the
//   same inputs and compares every cycle against a reference model built on
//   the idea "a level is adopted once S consecutive synchronised samples
//   disagree with the current level".
// ---------------------------------------------------------------------------
module tb_latch_out_debounce;

    localparam int S = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       d_in = 1'b0;
    logic       count_clear = 1'b0;

    logic       lvl_a, rise_a, fall_a;
    logic [7:0] cnt_a;
    logic       lvl_b, rise_b, fall_b;
    logic [1:0] cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic m_pipe [2];   // [0] = first flop, [1] = value seen by the filter
    logic m_level;
    int   m_run;
    int   m_count;
    logic m_rise, m_fall;

    always #5 clock = ~clock;

    latch_out_debounce #(.STABLE_CYCLES(S), .CNT_W(8)) dut_a (
        .clock(clock), .reset(reset), .d_in(d_in), .count_clear(count_clear),
        .level_out(lvl_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .edge_count(cnt_a)
    );

    latch_out_debounce #(.STABLE_CYCLES(S), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .d_in(d_in), .count_clear(count_clear),
        .level_out(lvl_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .edge_count(cnt_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe[0] = 1'b0;
        m_pipe[1] = 1'b0;
        m_level   = 1'b0;
        m_run     = 0;
        m_count   = 0;
        m_rise    = 1'b0;
        m_fall    = 1'b0;
    endtask

    // One clock edge of the model: the filtered sample is whatever the
    // synchroniser delivered two edges ago.
    task automatic model_edge(input logic d, input logic clr);
        logic smp;
        smp    = m_pipe[1];
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (smp != m_level) begin
            m_run++;
            if (m_run == S) begin
                m_level = smp;
                m_run   = 0;
                if (smp) m_rise = 1'b1;
                else     m_fall = 1'b1;
            end
        end else begin
            m_run = 0;
        end
        if (m_rise)   m_count = clr ? 1 : m_count + 1;
        else if (clr) m_count = 0;
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = d;
    endtask

    task automatic compare_all();
        check("level_a", int'(lvl_a), int'(m_level));
        check("rise_a",  int'(rise_a), int'(m_rise));
        check("fall_a",  int'(fall_a), int'(m_fall));
        check("count_a", int'(cnt_a), m_count % 256);
        check("level_b", int'(lvl_b), int'(m_level));
        check("rise_b",  int'(rise_b), int'(m_rise));
        check("fall_b",  int'(fall_b), int'(m_fall));
        check("count_b", int'(cnt_b), m_count % 4);
        check("no_both", int'(rise_a & fall_a), 0);
    endtask

    task automatic cycle(input logic d, input logic clr);
        d_in        = d;
        count_clear = clr;
        @(posedge clock);
        #1;
        model_edge(d, clr);
        compare_all();
    endtask

    initial begin
        model_reset();

        // Reset held with d_in high; everything must sit at zero.
        d_in = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        compare_all();
        #3 reset = 1'b0;   // released between edges, ahead of edge 0

        // Edges 0..4: level still low; edge 5: accepted rise.
        for (int e = 0; e <= 4; e++) begin
            cycle(1'b1, 1'b0);
            check("t1_low_before_accept", int'(lvl_a), 0);
        end
        cycle(1'b1, 1'b0);
        check("t1_level_edge5", int'(lvl_a), 1);
        check("t1_rise_edge5", int'(rise_a), 1);
        cycle(1'b1, 1'b0);
        check("t1_rise_edge6", int'(rise_a), 0);
        check("t1_count", int'(cnt_a), 1);

        // Falling acceptance, then a short high glitch that must be dropped.
        repeat (8) cycle(1'b0, 1'b0);
        check("t3_level_low", int'(lvl_a), 0);
        check("t3_count_kept", int'(cnt_a), 1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        repeat (8) cycle(1'b0, 1'b0);
        check("t2_glitch_level", int'(lvl_a), 0);
        check("t2_glitch_count", int'(cnt_a), 1);

        // Clear on the accepting edge keeps the event; clear alone zeroes.
        repeat (5) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        check("t5_rise", int'(rise_a), 1);
        check("t5_clear_with_rise", int'(cnt_a), 1);
        repeat (3) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        check("t5_clear_alone", int'(cnt_a), 0);

        // Five accepted rises on the narrow counter.
        for (int r = 0; r < 5; r++) begin
            repeat (7) cycle(1'b0, 1'b0);
            repeat (7) cycle(1'b1, 1'b0);
            check("t4_count_b", int'(cnt_b), (r + 1) % 4);
        end

        // Reset in the middle of a high qualification.
        repeat (8) cycle(1'b0, 1'b0);
        repeat (4) cycle(1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clock);
        #2 reset = 1'b0;
        for (int e = 0; e <= 4; e++) begin
            cycle(1'b1, 1'b0);
            check("t6_no_early_rise", int'(rise_a), 0);
        end
        cycle(1'b1, 1'b0);
        check("t6_requalified_rise", int'(rise_a), 1);

        // Randomised hold lengths, straddling the acceptance threshold.
        begin
            logic d_r;
            int   hold;
            d_r  = 1'b0;
            hold = 0;
            for (int i = 0; i < 1500; i++) begin
                if (hold == 0) begin
                    d_r  = ~d_r;
                    hold = $urandom_range(1, 8);
                end
                hold--;
                cycle(d_r, ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
